// File: rtl/rgb_axis_packer.sv
// rgb_axis_packer: packs 24-bit RGB pixels (byte stream b,g,r) into a 32-bit
// AXI4-Stream video stream, four pixels per three words, flushing partial words at EOL.
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   image_width           - expected pixels per line, sampled on an accepted SOF pixel
//   in_valid/in_ready     - pixel handshake (in_ready is combinational)
//   in_r/in_g/in_b        - pixel colour; in_sof/in_eol frame/line markers
//   m_axis_*              - registered AXI4-Stream master (tdata/tkeep/tvalid/tuser/tlast)
//   err_eol_early/late    - sticky line-length errors, cleared only by reset
module rgb_axis_packer #(
    parameter int unsigned WIDTH_BITS = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_BITS-1:0] image_width,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_r,
    input  logic [7:0]            in_g,
    input  logic [7:0]            in_b,
    input  logic                  in_sof,
    input  logic                  in_eol,
    output logic [31:0]           m_axis_tdata,
    output logic [3:0]            m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  err_eol_early,
    output logic                  err_eol_late
);

    typedef enum logic {S_PACK, S_FLUSH} state_t;

    state_t                state_q, state_d;
    logic [1:0]            phase_q, phase_d;
    logic [23:0]           res_q, res_d;
    logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;
    logic                  sof_pend_q, sof_pend_d;
    logic [31:0]           fl_data_q, fl_data_d;
    logic [3:0]            fl_keep_q, fl_keep_d;
    logic [31:0]           tdata_q, tdata_d;
    logic [3:0]            tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tuser_q, tuser_d;
    logic                  tlast_q, tlast_d;
    logic                  early_q, early_d;
    logic                  late_q, late_d;

    // Next-state logic: packing per phase, EOL flush, tuser and line-length checks
    always_comb begin
        logic [23:0]           pix;
        logic                  out_free;
        logic                  acc;
        logic [1:0]            eff_phase;
        logic [23:0]           eff_res;
        logic [WIDTH_BITS-1:0] eff_cnt;
        logic [WIDTH_BITS-1:0] eff_width;
        logic [WIDTH_BITS-1:0] cnt_plus;
        logic                  emit;
        logic [31:0]           word;
        logic [3:0]            keep;
        logic                  last;

        state_d    = state_q;
        phase_d    = phase_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        width_d    = width_q;
        sof_pend_d = sof_pend_q;
        fl_data_d  = fl_data_q;
        fl_keep_d  = fl_keep_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tvalid_d   = tvalid_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        early_d    = early_q;
        late_d     = late_q;

        pix       = {in_r, in_g, in_b};
        out_free  = ~tvalid_q | m_axis_tready;
        in_ready  = (state_q == S_PACK) & out_free;
        acc       = in_valid & in_ready;
        eff_phase = in_sof ? 2'd0 : phase_q;
        eff_res   = in_sof ? 24'd0 : res_q;
        eff_cnt   = in_sof ? '0 : cnt_q;
        eff_width = in_sof ? image_width : width_q;
        cnt_plus  = eff_cnt + WIDTH_BITS'(1);
        emit      = 1'b1;
        word      = 32'd0;
        keep      = 4'b1111;
        last      = in_eol;

        // Word drained with nothing new to load
        if (tvalid_q & m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            S_PACK: begin
                if (acc) begin
                    case (eff_phase)
                        2'd0: begin
                            res_d = pix;
                            if (in_eol) begin
                                word = {8'h00, pix};
                                keep = 4'b0111;
                            end else begin
                                emit = 1'b0;
                            end
                        end
                        2'd1: begin
                            word  = {pix[7:0], eff_res[23:0]};
                            res_d = {8'h00, pix[23:8]};
                            if (in_eol) begin
                                last      = 1'b0;
                                state_d   = S_FLUSH;
                                fl_data_d = {16'h0000, pix[23:8]};
                                fl_keep_d = 4'b0011;
                            end
                        end
                        2'd2: begin
                            word  = {pix[15:0], eff_res[15:0]};
                            res_d = {16'h0000, pix[23:16]};
                            if (in_eol) begin
                                last      = 1'b0;
                                state_d   = S_FLUSH;
                                fl_data_d = {24'h000000, pix[23:16]};
                                fl_keep_d = 4'b0001;
                            end
                        end
                        default: begin
                            word  = {pix, eff_res[7:0]};
                            res_d = 24'd0;
                        end
                    endcase

                    if (in_eol) begin
                        phase_d = 2'd0;
                        res_d   = 24'd0;
                    end else begin
                        phase_d = eff_phase + 2'd1;
                    end

                    if (emit) begin
                        tdata_d    = word;
                        tkeep_d    = keep;
                        tlast_d    = last;
                        tvalid_d   = 1'b1;
                        tuser_d    = sof_pend_q | in_sof;
                        sof_pend_d = 1'b0;
                    end else begin
                        sof_pend_d = sof_pend_q | in_sof;
                    end

                    width_d = eff_width;
                    if (in_eol) begin
                        if (cnt_plus < eff_width) begin
                            early_d = 1'b1;
                        end
                        cnt_d = '0;
                    end else begin
                        if (cnt_plus == eff_width) begin
                            late_d = 1'b1;
                        end
                        cnt_d = cnt_plus;
                    end
                end
            end
            S_FLUSH: begin
                // Residual bytes go out once the output register is free or draining
                if (out_free) begin
                    tdata_d    = fl_data_q;
                    tkeep_d    = fl_keep_q;
                    tlast_d    = 1'b1;
                    tvalid_d   = 1'b1;
                    tuser_d    = sof_pend_q;
                    sof_pend_d = 1'b0;
                    state_d    = S_PACK;
                end
            end
            default: state_d = S_PACK;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_PACK;
            phase_q    <= 2'd0;
            res_q      <= 24'd0;
            cnt_q      <= '0;
            width_q    <= '0;
            sof_pend_q <= 1'b0;
            fl_data_q  <= 32'd0;
            fl_keep_q  <= 4'd0;
            tdata_q    <= 32'd0;
            tkeep_q    <= 4'd0;
            tvalid_q   <= 1'b0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
            early_q    <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            width_q    <= width_d;
            sof_pend_q <= sof_pend_d;
            fl_data_q  <= fl_data_d;
            fl_keep_q  <= fl_keep_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tvalid_q   <= tvalid_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
            early_q    <= early_d;
            late_q     <= late_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign err_eol_early = early_q;
    assign err_eol_late  = late_q;

endmodule

// File: tb/tb_rgb_axis_packer.sv
// Bench for rgb_axis_packer: a byte-stream reference model fills a scoreboard of
// expected output words as pixels are accepted; a monitor pops and compares them.
module tb_rgb_axis_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] image_width = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
    logic        in_sof = 1'b0, in_eol = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        err_eol_early;
    logic        err_eol_late;

    rgb_axis_packer dut (
        .clk          (clk),
        .reset        (reset),
        .image_width  (image_width),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_r         (in_r),
        .in_g         (in_g),
        .in_b         (in_b),
        .in_sof       (in_sof),
        .in_eol       (in_eol),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .err_eol_early(err_eol_early),
        .err_eol_late (err_eol_late)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Scoreboard entry: {tuser, tlast, tkeep, tdata}
    logic [37:0] exp_q[$];
    logic [7:0]  line_q[$];
    bit          sof_pend_m = 1'b0;

    int words_cnt = 0, last_cnt = 0, user_cnt = 0;
    int tready_mode = 0; // 0: always ready, 1: random 50%, 2: never ready

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    // Reference: the line is a byte stream b,g,r per pixel, cut into 4-byte words
    function automatic void model_pixel(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b, input bit sof, input bit eol);
        if (sof) begin
            line_q.delete();
            sof_pend_m = 1'b1;
        end
        line_q.push_back(b);
        line_q.push_back(g);
        line_q.push_back(r);
        while ((eol && line_q.size() > 0) || line_q.size() >= 4) begin
            logic [31:0] d = '0;
            logic [3:0]  k = '0;
            int          n = (line_q.size() >= 4) ? 4 : line_q.size();
            for (int i = 0; i < n; i++) begin
                d[8*i +: 8] = line_q.pop_front();
                k[i] = 1'b1;
            end
            exp_q.push_back({sof_pend_m, (eol && line_q.size() == 0), k, d});
            sof_pend_m = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        line_q.delete();
        sof_pend_m = 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(1, 0));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard compare on handshake, stability check while stalled
    bit          stall_prev = 1'b0;
    logic [37:0] held = '0;
    always @(negedge clk) begin
        logic [37:0] got;
        logic [37:0] e;
        got = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests++;
                assert ({m_axis_tvalid, got} === {1'b1, held}) else begin
                    fails++;
                    $error("FAIL stall_stable got=%h expected=%h", {m_axis_tvalid, got}, {1'b1, held});
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                words_cnt++;
                if (m_axis_tlast) last_cnt++;
                if (m_axis_tuser) user_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $error("FAIL word_unexpected got=%h expected=none", got);
                end else begin
                    e = exp_q.pop_front();
                    assert (got === e) else begin
                        fails++;
                        $error("FAIL word got=%h expected=%h", got, e);
                    end
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held = got;
        end
    end

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input bit sof, input bit eol);
        bit got = 1'b0;
        in_r = r; in_g = g; in_b = b; in_sof = sof; in_eol = eol;
        in_valid = 1'b1;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (got) begin
            model_pixel(r, g, b, sof, eol);
            @(posedge clk);
            #1;
        end else begin
            chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eol = 1'b0;
    endtask

    // Send n pixels; SOF on the first if sof, EOL on index eol_at (-1: none)
    task automatic send_line(input int n, input bit sof, input int eol_at, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [7:0] r, g, b;
            if (rnd) begin
                r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            end else begin
                r = 8'(3*i + 1); g = 8'(3*i + 2); b = 8'(3*i + 3);
            end
            send(r, g, b, sof && (i == 0), i == eol_at);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tkeep,
                              m_axis_tdata, err_eol_early, err_eol_late}, 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // T1: 4-pixel line, phase-3 EOL
        image_width = 13'd4;
        send_line(4, 1'b1, 3, 1'b0);
        drain("t1_drain");

        // T2: 5-pixel line, phase-0 EOL
        image_width = 13'd5;
        send_line(5, 1'b1, 4, 1'b0);
        drain("t2_drain");

        // T3: 6-pixel line, phase-1 EOL needs one FLUSH cycle
        image_width = 13'd6;
        send_line(5, 1'b1, -1, 1'b0);
        send(8'h10, 8'h11, 8'h12, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_flush_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("t3_in_ready_back", 64'(in_ready), 64'd1);
        drain("t3_drain");
        chk("t3_no_errors", {err_eol_early, err_eol_late}, 64'd0);

        // T4: 640x4 frame with random backpressure
        image_width = 13'd640;
        words_cnt = 0; last_cnt = 0; user_cnt = 0;
        tready_mode = 1;
        for (int l = 0; l < 4; l++) send_line(640, l == 0, 639, 1'b1);
        drain("t4_drain");
        tready_mode = 0;
        chk("t4_word_count", 64'(words_cnt), 64'd1920);
        chk("t4_tlast_count", 64'(last_cnt), 64'd4);
        chk("t4_tuser_count", 64'(user_cnt), 64'd1);
        chk("t4_no_errors", {err_eol_early, err_eol_late}, 64'd0);

        // T5: early and late EOL, both sticky
        image_width = 13'd8;
        send_line(7, 1'b1, 6, 1'b0);
        drain("t5a_drain");
        chk("t5_early_only", {err_eol_early, err_eol_late}, 64'b10);
        image_width = 13'd4;
        send_line(6, 1'b1, 5, 1'b0);
        drain("t5b_drain");
        chk("t5_both_set", {err_eol_early, err_eol_late}, 64'b11);
        send_line(4, 1'b1, 3, 1'b0);
        drain("t5c_drain");
        chk("t5_sticky", {err_eol_early, err_eol_late}, 64'b11);

        // T6: reset while in FLUSH with a stalled output word
        tready_mode = 2;
        @(posedge clk);
        #1;
        image_width = 13'd2;
        send(8'h21, 8'h22, 8'h23, 1'b1, 1'b0);
        send(8'h24, 8'h25, 8'h26, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_stalled_flush", {m_axis_tvalid, in_ready}, 64'b10);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        tready_mode = 0;
        @(negedge clk);
        chk("t6_after_reset", {m_axis_tvalid, in_ready, err_eol_early, err_eol_late}, 64'b0100);
        image_width = 13'd4;
        send_line(4, 1'b1, 3, 1'b0);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
